line_shifter: RTL and testbench
===============================

LINE_SHIFTER -- requirements
Module: line_shifter

Interface
REQ-001 Parameter: DEPTH_LOG2, 4, log2 of the word FIFO depth (default depth 16 words).
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 reset_i  in  1  synchronous, active-high reset.
REQ-004 dat_i  in  16  framebuffer read data, valid when cyc_i & ack_i.
REQ-005 ack_i  in  1  bus cycle acknowledge, the same signal seen by the fetcher.
REQ-006 cyc_i  in  1  fetcher cyc_o, meaning a framebuffer fetch is in progress.
REQ-007 hsync_i  in  1  CRTC HSYNC, active high.
REQ-008 vsync_i  in  1  CRTC VSYNC, active high.
REQ-009 blank_i  in  1  CRTC blanking, active high; low means visible pixel region.
REQ-010 dot_en_i  in  1  pixel-clock enable; one pixel per asserted cycle.
REQ-011 err_clr_i  in  1  clears the sticky error flags.
REQ-012 pixel_o  out  1  registered monochrome pixel.
REQ-013 level_o  out  DEPTH_LOG2+1  FIFO occupancy, 0..2^DEPTH_LOG2.
REQ-014 full_o, empty_o  out  1 each  FIFO full and FIFO empty, derived combinationally from level_o.
REQ-015 overflow_o, underrun_o  out  1 each  sticky error flags.

Function
REQ-016 Write event: cyc_i & ack_i & ~vsync_i; dat_i is pushed to the FIFO tail if ~full_o.
REQ-017 A write event while full_o drops the word, sets overflow_o, and leaves the FIFO unchanged.
REQ-018 Pixel tick: dot_en_i & ~blank_i & ~hsync_i & ~vsync_i.
REQ-019 The shifter holds a 16-bit shift register (shreg) and a 5-bit counter bits_left (0..16).
REQ-020 Tick with bits_left==0 and ~empty_o:
  - pop the FIFO head word W;
  - pixel_o<=W[15];
  - shreg<={W[14:0],1'b0};
  - bits_left<=15.
REQ-021 Tick with bits_left==0 and empty_o:
  - pixel_o<=0;
  - set underrun_o;
  - no pop; shreg and bits_left are unchanged.
REQ-022 Tick with bits_left>0:
  - pixel_o<=shreg[15];
  - shreg shifts left one bit, filling with 0;
  - bits_left decrements.
REQ-023 Pixels are emitted MSB first; word latency from FIFO head to its first pixel is 1 cycle after the tick.
REQ-024 No tick while blank_i is high: pixel_o<=0, and shreg and bits_left hold.
REQ-025 dot_en_i low while visible: pixel_o, shreg and bits_left all hold.
REQ-026 hsync_i high: bits_left<=0 and pixel_o<=0, discarding any partial word; FIFO contents are preserved, so fetches that start during HSYNC are kept.
REQ-027 vsync_i high: FIFO pointers are cleared (level_o<=0), bits_left<=0, pixel_o<=0, and writes are suppressed.
REQ-028 A simultaneous push and pop in one cycle are both performed; level_o is unchanged, including when full (a pop frees the slot for the same-cycle push, so no overflow).
REQ-029 The FIFO uses DEPTH_LOG2-bit read/write pointers with natural wrap-around; level_o is exact at 0 and at 2^DEPTH_LOG2.
REQ-030 err_clr_i clears both sticky flags; if a new error occurs in the same cycle, the flag remains set (set has priority).
REQ-031 level_o updates one cycle after the push/pop event; full_o and empty_o follow level_o.

Reset
REQ-032 reset_i high at an edge forces:
  - pixel_o=0, level_o=0, empty_o=1, full_o=0;
  - overflow_o=0, underrun_o=0;
  - bits_left=0, shreg=0, FIFO pointers=0.
REQ-033 reset_i has priority over all other inputs, including mid-word and mid-fetch; FIFO RAM contents need not be cleared.

Verification
REQ-034 Push 0xA5F0 and 0x8001 (blank_i=1), then 32 consecutive ticks -> pixel_o=1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0,1,0...0,1; level_o goes 2->1->0; underrun_o stays 0.
REQ-035 Push 17 words with no ticks -> level_o=16, full_o=1, overflow_o=1, 17th word absent from the output stream; assert err_clr_i -> overflow_o=0.
REQ-036 With level_o=16, push and pop in the same cycle -> level_o=16 and overflow_o=0.
REQ-037 Pop one word, 5 ticks, then pulse hsync_i -> next tick pops a fresh word with its MSB first; earlier buffered words remain in order.
REQ-038 Empty FIFO, one tick -> pixel_o=0, underrun_o=1; vsync_i with writes present -> level_o=0 and no words stored.
REQ-039 Assert reset_i after 7 pixels of a word with level_o=3 -> all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/line_shifter.sv
// rtl/line_shifter.sv - framebuffer word FIFO feeding an MSB-first monochrome pixel shifter
module line_shifter #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [15:0]           dat_i,
    input  logic                  ack_i,
    input  logic                  cyc_i,
    input  logic                  hsync_i,
    input  logic                  vsync_i,
    input  logic                  blank_i,
    input  logic                  dot_en_i,
    input  logic                  err_clr_i,
    output logic                  pixel_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  overflow_o,
    output logic                  underrun_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE    = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = 1;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [15:0]           shreg;
    logic [4:0]            bits_left;
    logic [15:0]           head;

    logic write_ev, tick, word_done, pop, push, overflow_set, underrun_set;

    assign full_o  = (level_o == FULL_LEVEL);
    assign empty_o = (level_o == '0);
    assign head    = mem[rd_ptr];

    assign write_ev  = cyc_i & ack_i & ~vsync_i;
    assign tick      = dot_en_i & ~blank_i & ~hsync_i & ~vsync_i;
    assign word_done = (bits_left == 5'd0);
    assign pop       = tick & word_done & ~empty_o;
    // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
    assign push         = write_ev & (~full_o | pop);
    assign overflow_set = write_ev & full_o & ~pop;
    assign underrun_set = tick & word_done & empty_o;

    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            mem[wr_ptr] <= dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || vsync_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level_o <= level_o + LVL_ONE;
                2'b01:   level_o <= level_o - LVL_ONE;
                default: level_o <= level_o;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pixel_o   <= 1'b0;
            shreg     <= '0;
            bits_left <= '0;
        end else if (vsync_i || hsync_i) begin
            pixel_o   <= 1'b0;
            bits_left <= '0;
        end else if (blank_i) begin
            pixel_o <= 1'b0;
        end else if (dot_en_i) begin
            if (word_done) begin
                if (!empty_o) begin
                    pixel_o   <= head[15];
                    shreg     <= {head[14:0], 1'b0};
                    bits_left <= 5'd15;
                end else begin
                    pixel_o <= 1'b0;
                end
            end else begin
                pixel_o   <= shreg[15];
                shreg     <= {shreg[14:0], 1'b0};
                bits_left <= bits_left - 5'd1;
            end
        end
    end

    // Set wins over clear so an error in the clearing cycle is not lost.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow_o <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            overflow_o <= (overflow_o & ~err_clr_i) | overflow_set;
            underrun_o <= (underrun_o & ~err_clr_i) | underrun_set;
        end
    end

endmodule

// File: tb/tb_line_shifter.sv
// tb/tb_line_shifter.sv - self-checking bench for line_shifter
module tb_line_shifter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i = 1'b1;
    logic [15:0] dat_i = '0;
    logic        ack_i = 1'b0, cyc_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0;
    logic        blank_i = 1'b1, dot_en_i = 1'b0, err_clr_i = 1'b0;
    logic        pixel_o, full_o, empty_o, overflow_o, underrun_o;
    logic [4:0]  level_o;

    line_shifter #(.DEPTH_LOG2(4)) dut (
        .clk_i(clk), .reset_i(reset_i), .dat_i(dat_i), .ack_i(ack_i), .cyc_i(cyc_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_i(blank_i), .dot_en_i(dot_en_i),
        .err_clr_i(err_clr_i), .pixel_o(pixel_o), .level_o(level_o), .full_o(full_o),
        .empty_o(empty_o), .overflow_o(overflow_o), .underrun_o(underrun_o)
    );

    typedef struct {
        logic        rst, cyc, ack;
        logic [15:0] dat;
        logic        hs, vs, bl, de, clr;
    } in_t;

    typedef struct {
        in_t        i;
        logic       px;
        logic [4:0] lvl;
        logic       und;
    } tv_t;

    int checks = 0;
    int failures = 0;

    // Reference model: a word queue and a queue of not-yet-shown pixels of the current word.
    logic [15:0] m_fifo[$];
    bit          m_bits[$];
    logic        m_px = 1'b0, m_ovf = 1'b0, m_und = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic rst, cyc, ack, input logic [15:0] dat,
                               input logic hs, vs, bl, de, clr);
        in_t v;
        v.rst = rst; v.cyc = cyc; v.ack = ack; v.dat = dat;
        v.hs = hs; v.vs = vs; v.bl = bl; v.de = de; v.clr = clr;
        return v;
    endfunction

    task automatic model_update(input in_t v);
        logic        popped;
        logic        ovf_set, und_set;
        logic [15:0] w;
        popped = 1'b0; ovf_set = 1'b0; und_set = 1'b0;
        if (v.rst) begin
            m_fifo.delete(); m_bits.delete();
            m_px = 1'b0; m_ovf = 1'b0; m_und = 1'b0;
            return;
        end
        if (v.vs) begin
            m_fifo.delete(); m_bits.delete();
            m_px = 1'b0;
        end else begin
            if (v.hs) begin
                m_bits.delete();
                m_px = 1'b0;
            end else if (v.bl) begin
                m_px = 1'b0;
            end else if (v.de) begin
                if (m_bits.size() == 0) begin
                    if (m_fifo.size() > 0) begin
                        w = m_fifo.pop_front();
                        for (int b = 15; b >= 0; b--) m_bits.push_back(w[b]);
                        m_px = m_bits.pop_front();
                        popped = 1'b1;
                    end else begin
                        m_px = 1'b0;
                        und_set = 1'b1;
                    end
                end else begin
                    m_px = m_bits.pop_front();
                end
            end
            if (v.cyc && v.ack) begin
                if (m_fifo.size() < 16) m_fifo.push_back(v.dat);
                else ovf_set = 1'b1;
            end
        end
        m_ovf = (m_ovf & ~v.clr) | ovf_set;
        m_und = (m_und & ~v.clr) | und_set;
    endtask

    task automatic step(input in_t v);
        reset_i = v.rst; cyc_i = v.cyc; ack_i = v.ack; dat_i = v.dat;
        hsync_i = v.hs; vsync_i = v.vs; blank_i = v.bl; dot_en_i = v.de; err_clr_i = v.clr;
        model_update(v);
        @(posedge clk);
        #1;
        chk("pixel", int'(pixel_o), int'(m_px));
        chk("level", int'(level_o), m_fifo.size());
        chk("full", int'(full_o), int'(m_fifo.size() == 16));
        chk("empty", int'(empty_o), int'(m_fifo.size() == 0));
        chk("overflow", int'(overflow_o), int'(m_ovf));
        chk("underrun", int'(underrun_o), int'(m_und));
    endtask

    task automatic do_reset();
        step(mk(1, 0, 0, 16'h0, 0, 0, 1, 0, 0));
    endtask
    task automatic do_push(input logic [15:0] w);
        step(mk(0, 1, 1, w, 0, 0, 1, 0, 0));
    endtask
    task automatic do_tick();
        step(mk(0, 0, 0, 16'h0, 0, 0, 0, 1, 0));
    endtask

    tv_t         tv[34];
    logic [31:0] pat;

    initial begin
        @(posedge clk); #1;

        // Reset state
        do_reset();
        chk("rst_pixel", int'(pixel_o), 0);
        chk("rst_level", int'(level_o), 0);
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_full", int'(full_o), 0);
        chk("rst_flags", int'({overflow_o, underrun_o}), 0);

        // Two words then 32 ticks: MSB-first stream
        pat = 32'hA5F0_8001;
        tv[0] = '{i: mk(0, 1, 1, 16'hA5F0, 0, 0, 1, 0, 0), px: 1'b0, lvl: 5'd1, und: 1'b0};
        tv[1] = '{i: mk(0, 1, 1, 16'h8001, 0, 0, 1, 0, 0), px: 1'b0, lvl: 5'd2, und: 1'b0};
        for (int k = 0; k < 32; k++) begin
            tv[k + 2].i   = mk(0, 0, 0, 16'h0, 0, 0, 0, 1, 0);
            tv[k + 2].px  = pat[31 - k];
            tv[k + 2].lvl = (k < 16) ? 5'd1 : 5'd0;
            tv[k + 2].und = 1'b0;
        end
        for (int n = 0; n < 34; n++) begin
            step(tv[n].i);
            chk("tbl_pixel", int'(pixel_o), int'(tv[n].px));
            chk("tbl_level", int'(level_o), int'(tv[n].lvl));
            chk("tbl_underrun", int'(underrun_o), int'(tv[n].und));
        end

        // Overflow: 17 pushes, clear, then push+pop while full
        do_reset();
        for (int n = 0; n < 17; n++) do_push(16'(16'h9C31 + n * 16'h1357));
        chk("ovf_level", int'(level_o), 16);
        chk("ovf_full", int'(full_o), 1);
        chk("ovf_flag", int'(overflow_o), 1);
        step(mk(0, 0, 0, 16'h0, 0, 0, 1, 0, 1));
        chk("ovf_clear", int'(overflow_o), 0);
        step(mk(0, 1, 1, 16'hBEEF, 0, 0, 0, 1, 0));
        chk("pushpop_level", int'(level_o), 16);
        chk("pushpop_ovf", int'(overflow_o), 0);
        for (int n = 0; n < 17 * 16 - 1; n++) do_tick();
        chk("drain_level", int'(level_o), 0);
        chk("drain_underrun", int'(underrun_o), 0);

        // HSYNC discards the partial word; buffered words stay in order
        do_reset();
        do_push(16'h7123); do_push(16'hC456); do_push(16'h3789);
        for (int n = 0; n < 6; n++) do_tick();
        step(mk(0, 0, 0, 16'h0, 1, 0, 0, 1, 0));
        do_tick();
        chk("hsync_msb", int'(pixel_o), 1);
        chk("hsync_level", int'(level_o), 1);
        for (int n = 0; n < 40; n++) do_tick();

        // Underrun on empty FIFO; VSYNC clears and blocks writes
        do_reset();
        do_tick();
        chk("und_pixel", int'(pixel_o), 0);
        chk("und_flag", int'(underrun_o), 1);
        do_push(16'h1111); do_push(16'h2222);
        step(mk(0, 1, 1, 16'h3333, 0, 1, 0, 1, 0));
        step(mk(0, 1, 1, 16'h4444, 0, 1, 0, 1, 0));
        chk("vsync_level", int'(level_o), 0);

        // Reset mid-word with three words buffered
        do_reset();
        for (int n = 0; n < 4; n++) do_push(16'(16'hFFFF - n));
        for (int n = 0; n < 7; n++) do_tick();
        chk("pre_rst_level", int'(level_o), 3);
        step(mk(1, 1, 1, 16'hAAAA, 0, 0, 0, 1, 0));
        chk("midrst_pixel", int'(pixel_o), 0);
        chk("midrst_level", int'(level_o), 0);
        chk("midrst_empty", int'(empty_o), 1);
        for (int n = 0; n < 20; n++) do_tick();

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            in_t v;
            v.rst = ($urandom_range(0, 299) == 0);
            v.cyc = ($urandom_range(0, 2) != 0);
            v.ack = ($urandom_range(0, 1) != 0);
            v.dat = 16'($urandom);
            v.hs  = ($urandom_range(0, 39) == 0);
            v.vs  = ($urandom_range(0, 149) == 0);
            v.bl  = ($urandom_range(0, 4) == 0);
            v.de  = ($urandom_range(0, 3) != 0);
            v.clr = ($urandom_range(0, 29) == 0);
            step(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
